// File: rtl/chacha_stream_xor_pkg.sv
// Shared types, sizes and keystream word selection for the ChaCha stream XOR front end.
package chacha_pkg;

    localparam int KS_WORDS = 16;
    localparam int WORD_W   = 32;
    localparam int BLOCK_W  = 512;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_REQ       = 3'd3,
        ST_GUARD     = 3'd4,
        ST_WAIT_KS   = 3'd5,
        ST_STREAM    = 3'd6
    } chacha_state_e;

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [WORD_W-1:0] ks_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [3:0]         idx);
        ks_word = '0;
        for (int i = 0; i < KS_WORDS; i++) begin
            if (idx == i[3:0]) begin
                ks_word = blk[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
        end
    endfunction

endpackage

// File: rtl/chacha_stream_xor_if.sv
// Valid/ready word stream in (s_*) and out (m_*) of the ChaCha stream XOR block.
interface chacha_stream_xor_if;
    import chacha_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/chacha_stream_xor_ks_buf.sv
// Keystream block buffer: 512-bit capture register, word index counter and word mux.
module chacha_ks_buf
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_adv,
    input  logic [BLOCK_W-1:0] i_block,
    output logic [3:0]         o_widx,
    output logic [WORD_W-1:0]  o_word
);

    logic [BLOCK_W-1:0] r_buf;
    logic [3:0]         r_widx;

    // Buffer contents are only read after a fresh load, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_buf <= i_block;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_widx <= 4'd0;
        end else if (i_load) begin
            r_widx <= 4'd0;
        end else if (i_adv) begin
            r_widx <= r_widx + 4'd1;
        end
    end

    assign o_widx = r_widx;
    assign o_word = ks_word(r_buf, r_widx);

endmodule

// File: rtl/chacha_stream_xor.sv
// ChaCha core initiator: sequences init/next, buffers each keystream block and XORs it into a word stream.
module chacha_stream_xor
    import chacha_pkg::*;
#(
    parameter logic [4:0] ROUNDS = 5'h14
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [255:0]        key,
    input  logic [63:0]         iv,
    input  logic [63:0]         ctr,
    output logic                busy,
    chacha_stream_xor_if.slave  strm,
    output logic [31:0]         block_cnt,
    output logic                core_init,
    output logic                core_next,
    output logic                core_keylen,
    output logic [255:0]        core_key,
    output logic [63:0]         core_iv,
    output logic [63:0]         core_ctr,
    output logic [4:0]          core_rounds,
    output logic [511:0]        core_data_in,
    input  logic                core_ready,
    input  logic                core_data_out_valid,
    input  logic [511:0]        core_data_out
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_INIT      = ST_INIT;
    localparam logic [2:0] S_WAIT_INIT = ST_WAIT_INIT;
    localparam logic [2:0] S_REQ       = ST_REQ;
    localparam logic [2:0] S_GUARD     = ST_GUARD;
    localparam logic [2:0] S_WAIT_KS   = ST_WAIT_KS;
    localparam logic [2:0] S_STREAM    = ST_STREAM;

    logic [2:0]        r_state;
    logic              r_guard;
    logic [31:0]       r_block_cnt;
    logic [255:0]      r_core_key;
    logic [63:0]       r_core_iv;
    logic [63:0]       r_core_ctr;
    logic              r_m_valid;
    logic              r_m_last;
    logic [WORD_W-1:0] r_m_data;

    logic              w_s_ready;
    logic              w_hs;
    logic              w_ks_load;
    logic [3:0]        w_widx;
    logic [WORD_W-1:0] w_ks_word;

    assign w_s_ready = (r_state == S_STREAM) && (!r_m_valid || strm.m_ready);
    assign w_hs      = strm.s_valid && w_s_ready;
    assign w_ks_load = (r_state == S_WAIT_KS) && core_ready && core_data_out_valid;

    chacha_ks_buf u_ks_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_ks_load),
        .i_adv   (w_hs),
        .i_block (core_data_out),
        .o_widx  (w_widx),
        .o_word  (w_ks_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_guard     <= 1'b0;
            r_block_cnt <= 32'd0;
            r_core_key  <= '0;
            r_core_iv   <= '0;
            r_core_ctr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_core_key  <= key;
                        r_core_iv   <= iv;
                        r_core_ctr  <= ctr;
                        r_block_cnt <= 32'd0;
                        r_state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_guard <= 1'b1;
                    r_state <= S_WAIT_INIT;
                end
                // The first WAIT_INIT cycle still sees the core's pre-init ready.
                S_WAIT_INIT: begin
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (core_ready) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_state <= S_GUARD;
                end
                S_GUARD: begin
                    r_state <= S_WAIT_KS;
                end
                S_WAIT_KS: begin
                    if (w_ks_load) begin
                        r_block_cnt <= r_block_cnt + 32'd1;
                        r_state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (strm.s_last) begin
                            r_state <= S_IDLE;
                        end else if (w_widx == 4'd15) begin
                            r_state <= S_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output word register; keeps draining after the FSM has returned to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (w_hs) begin
            r_m_valid <= 1'b1;
            r_m_last  <= strm.s_last;
            r_m_data  <= strm.s_data ^ w_ks_word;
        end else if (strm.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign core_init    = (r_state == S_INIT);
    assign core_next    = (r_state == S_REQ);
    assign core_keylen  = 1'b1;
    assign core_key     = r_core_key;
    assign core_iv      = r_core_iv;
    assign core_ctr     = r_core_ctr;
    assign core_rounds  = ROUNDS;
    assign core_data_in = '0;
    assign block_cnt    = r_block_cnt;

    assign strm.s_ready = w_s_ready;
    assign strm.m_valid = r_m_valid;
    assign strm.m_last  = r_m_last;
    assign strm.m_data  = r_m_data;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor with a behavioural stand-in for chacha_core.
module tb_chacha_stream_xor;

    localparam int TINIT = 3;
    localparam int TBLK  = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [255:0] key;
    logic [63:0]  iv;
    logic [63:0]  ctr;
    logic         busy;
    logic [31:0]  block_cnt;
    logic         core_init, core_next, core_keylen;
    logic [255:0] core_key;
    logic [63:0]  core_iv, core_ctr;
    logic [4:0]   core_rounds;
    logic [511:0] core_data_in;
    logic         core_ready, core_valid;
    logic [511:0] core_dout;

    int checks = 0;
    int errors = 0;

    chacha_stream_xor_if sif();

    chacha_stream_xor u_dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .key                 (key),
        .iv                  (iv),
        .ctr                 (ctr),
        .busy                (busy),
        .strm                (sif),
        .block_cnt           (block_cnt),
        .core_init           (core_init),
        .core_next           (core_next),
        .core_keylen         (core_keylen),
        .core_key            (core_key),
        .core_iv             (core_iv),
        .core_ctr            (core_ctr),
        .core_rounds         (core_rounds),
        .core_data_in        (core_data_in),
        .core_ready          (core_ready),
        .core_data_out_valid (core_valid),
        .core_data_out       (core_dout)
    );

    always #5 clk = ~clk;

    // Stand-in keystream: word i of block b is key[31:0] ^ {b[7:0], 8'h5A, 8'hC3, i[7:0]}.
    function automatic logic [31:0] exp_ks(input logic [255:0] k, input logic [63:0] b, input int i);
        logic [7:0] ib;
        ib = i[7:0];
        exp_ks = k[31:0] ^ {b[7:0], 8'h5A, 8'hC3, ib};
    endfunction

    function automatic logic [511:0] mk_block(input logic [255:0] k, input logic [63:0] b);
        mk_block = '0;
        for (int i = 0; i < 16; i++) mk_block[511-32*i -: 32] = exp_ks(k, b, i);
    endfunction

    int          cm_cnt;
    logic        cm_gen;
    logic [63:0] cm_blk;

    always @(posedge clk) begin
        if (!reset_n) begin
            core_ready <= 1'b1;
            core_valid <= 1'b0;
            cm_cnt     <= 0;
            cm_gen     <= 1'b0;
            cm_blk     <= '0;
        end else if (core_init) begin
            core_ready <= 1'b0;
            core_valid <= 1'b0;
            cm_cnt     <= TINIT;
            cm_gen     <= 1'b0;
            cm_blk     <= core_ctr;
        end else if (core_next) begin
            core_ready <= 1'b0;
            core_valid <= 1'b0;
            cm_cnt     <= TBLK;
            cm_gen     <= 1'b1;
        end else if (cm_cnt > 1) begin
            cm_cnt <= cm_cnt - 1;
        end else if (cm_cnt == 1) begin
            cm_cnt     <= 0;
            core_ready <= 1'b1;
            if (cm_gen) begin
                core_valid <= 1'b1;
                core_dout  <= mk_block(core_key, cm_blk);
                cm_blk     <= cm_blk + 64'd1;
            end
        end
    end

    logic [31:0] out_q[$];
    logic        last_q[$];
    int          n_next = 0;
    int          n_init = 0;

    always @(negedge clk) begin
        if (reset_n && sif.m_valid && sif.m_ready) begin
            out_q.push_back(sif.m_data);
            last_q.push_back(sif.m_last);
        end
        if (core_next) n_next <= n_next + 1;
        if (core_init) n_init <= n_init + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t;
        t = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = l;
        @(negedge clk);
        while (!sif.s_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!sif.s_ready) check("send_wait_s_ready", {63'd0, sif.s_ready}, 64'd1);
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string tag);
        int t;
        t = 0;
        while (out_q.size() < n && t < 300) begin
            t++;
            @(negedge clk);
        end
        check(tag, out_q.size(), n);
    endtask

    task automatic do_start(input logic [255:0] k, input logic [63:0] v, input logic [63:0] c);
        key   = k;
        iv    = v;
        ctr   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k1, k2;
        logic [63:0]  iv1;
        logic [31:0]  ct[32];
        int ob, nb, ib;

        k1  = {4{64'h0123456789abcdef}};
        k2  = {4{64'hfedcba9876543210}};
        iv1 = 64'hdeadbeefcafebabe;
        reset_n = 1'b0;
        start   = 1'b1;
        key     = k1;
        iv      = iv1;
        ctr     = 64'h55;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        sif.m_ready = 1'b1;

        // Reset state, with start held high and ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_s_ready", sif.s_ready, 0);
        check("rst_m_valid", sif.m_valid, 0);
        check("rst_m_last", sif.m_last, 0);
        check("rst_m_data", sif.m_data, 0);
        check("rst_block_cnt", block_cnt, 0);
        check("rst_core_init", core_init, 0);
        check("rst_core_next", core_next, 0);
        check("rst_core_key", core_key[63:0], 0);
        check("rst_core_ctr", core_ctr, 0);
        check("tie_keylen", core_keylen, 1);
        check("tie_rounds", core_rounds, 5'h14);
        check("tie_data_in", {63'd0, |core_data_in}, 0);
        @(posedge clk);
        #1;
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Zero plaintext, one full block.
        ob = out_q.size(); nb = n_next; ib = n_init;
        do_start(k1, iv1, 64'd0);
        @(negedge clk);
        check("t1_core_init", core_init, 1);
        check("t1_busy", busy, 1);
        check("t1_s_ready_init", sif.s_ready, 0);
        check("t1_core_key_hi", core_key[255:192], 64'h0123456789abcdef);
        check("t1_core_iv", core_iv, 64'hdeadbeefcafebabe);
        check("t1_core_ctr", core_ctr, 64'd0);
        for (int i = 0; i < 16; i++) send(32'd0, i == 15);
        wait_out(ob + 16, "t1_count");
        check("t1_w0", out_q[ob], 32'h89f10eef);
        check("t1_w15", out_q[ob+15], 32'h89f10ee0);
        for (int i = 0; i < 16; i++) check($sformatf("t1_word%0d", i), out_q[ob+i], exp_ks(k1, 64'd0, i));
        check("t1_last", last_q[ob+15], 1);
        check("t1_block_cnt", block_cnt, 1);
        check("t1_next_pulses", n_next - nb, 1);
        check("t1_init_pulses", n_init - ib, 1);
        check("t1_idle", busy, 0);

        // 17 words: refill after word 15.
        ob = out_q.size(); nb = n_next;
        do_start(k1, iv1, 64'd0);
        for (int i = 0; i < 17; i++) begin
            send(32'h11110000 + i, i == 16);
            if (i == 15) begin
                @(negedge clk);
                check("t2_refill_s_ready", sif.s_ready, 0);
                check("t2_refill_busy", busy, 1);
            end
        end
        wait_out(ob + 17, "t2_count");
        for (int i = 0; i < 16; i++) check($sformatf("t2_word%0d", i), out_q[ob+i], (32'h11110000 + i) ^ exp_ks(k1, 64'd0, i));
        check("t2_word16", out_q[ob+16], 32'h99e00eff);
        check("t2_last15", last_q[ob+15], 0);
        check("t2_last16", last_q[ob+16], 1);
        check("t2_block_cnt", block_cnt, 2);
        check("t2_next_pulses", n_next - nb, 2);

        // Backpressure: m_ready low for 5 cycles after word 3 is loaded.
        ob = out_q.size();
        do_start(k1, iv1, 64'd5);
        for (int i = 0; i < 4; i++) send(32'ha0a0a0a0 ^ i, 1'b0);
        sif.m_ready = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = 32'ha0a0a0a4;
        sif.s_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_s_ready", sif.s_ready, 0);
            check("t3_hold_m_data", sif.m_data, 32'h2c51ae4f);
        end
        @(posedge clk);
        #1;
        sif.m_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(32'ha0a0a0a0 ^ i, i == 7);
        wait_out(ob + 8, "t3_count");
        repeat (3) @(negedge clk);
        check("t3_no_dup", out_q.size(), ob + 8);
        for (int i = 0; i < 8; i++) check($sformatf("t3_word%0d", i), out_q[ob+i], (32'ha0a0a0a0 ^ i) ^ exp_ks(k1, 64'd5, i));
        @(posedge clk);
        #1;

        // Early last on word 3, then a fresh start.
        ob = out_q.size(); nb = n_next;
        do_start(k1, iv1, 64'h10);
        for (int i = 0; i < 4; i++) send(32'h0 + i, i == 3);
        wait_out(ob + 4, "t4_count");
        check("t4_idle", busy, 0);
        check("t4_block_cnt", block_cnt, 1);
        check("t4_next_pulses", n_next - nb, 1);
        check("t4_word3", out_q[ob+3], 32'h3 ^ exp_ks(k1, 64'h10, 3));
        @(posedge clk);
        #1;
        ob = out_q.size(); ib = n_init;
        do_start(k1, iv1, 64'h20);
        send(32'h12345678, 1'b1);
        wait_out(ob + 1, "t4b_count");
        check("t4b_init_again", n_init - ib, 1);
        check("t4b_word0", out_q[ob], 32'hbbc55897);

        // Reset for one cycle after word 7.
        @(posedge clk);
        #1;
        do_start(k1, iv1, 64'd0);
        for (int i = 0; i < 8; i++) send(32'hc0de0000 + i, 1'b0);
        reset_n = 1'b0;
        start   = 1'b1;
        key     = k2;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_s_ready", sif.s_ready, 0);
        check("t5_m_valid", sif.m_valid, 0);
        check("t5_m_last", sif.m_last, 0);
        check("t5_m_data", sif.m_data, 0);
        check("t5_block_cnt", block_cnt, 0);
        check("t5_core_key", core_key[63:0], 0);
        check("t5_core_init", core_init, 0);
        repeat (2) @(negedge clk);
        check("t5_still_idle", busy, 0);
        @(posedge clk);
        #1;

        // Round trip: encrypt 32 words, then decrypt the ciphertext with the same key/iv/ctr.
        ob = out_q.size();
        do_start(k2, iv1, 64'd7);
        for (int i = 0; i < 32; i++) send(i + 1, i == 31);
        wait_out(ob + 32, "t6_enc_count");
        for (int i = 0; i < 32; i++) ct[i] = out_q[ob+i];
        check("t6_ct0", ct[0], 32'h710ef111);
        check("t6_block_cnt", block_cnt, 2);
        @(posedge clk);
        #1;
        ob = out_q.size();
        do_start(k2, iv1, 64'd7);
        for (int i = 0; i < 32; i++) send(ct[i], i == 31);
        wait_out(ob + 32, "t6_dec_count");
        for (int i = 0; i < 32; i++) check($sformatf("t6_pt%0d", i), out_q[ob+i], i + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
